// File: rtl/regfile_bypass_if.sv
// Register-file port bundle: two read-address/data pairs, one write port.
// The master drives addresses and write data; the slave returns combinational read data.
interface regfile_bypass_if #(
    parameter int unsigned N  = 64,
    parameter int unsigned AW = 5
);
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [AW-1:0] rw;
    logic          reg_wr;
    logic [N-1:0]  bus_w;
    logic [N-1:0]  bus_a_c;
    logic [N-1:0]  bus_b_c;

    modport master (
        output ra, rb, rw, reg_wr, bus_w,
        input  bus_a_c, bus_b_c
    );

    modport slave (
        input  ra, rb, rw, reg_wr, bus_w,
        output bus_a_c, bus_b_c
    );
endinterface

// File: rtl/regfile_bypass.sv
// 32 x 64-bit register file, X31 reads as zero, with same-cycle write-to-read bypass.
// Reads are combinational; an asserted reset forces both read buses to zero.
module regfile_bypass (
    input  logic            clk,
    input  logic            rst,
    regfile_bypass_if.slave rf
);
    localparam int unsigned N        = 64;
    localparam int unsigned AW       = 5;
    localparam int unsigned NUM_ARCH = 32;
    localparam int unsigned NUM_PHYS = 31;
    localparam logic [AW-1:0] XZR    = AW'(NUM_ARCH - 1);

    logic [N-1:0]        x_q    [NUM_PHYS];
    logic [N-1:0]        x_d    [NUM_PHYS];
    logic [N-1:0]        view_c [NUM_ARCH];
    logic [NUM_PHYS-1:0] wr_en_c;
    logic [N-1:0]        rd_a_c;
    logic [N-1:0]        rd_b_c;

    // One-hot write decode; a write aimed at XZR selects nothing.
    always_comb begin
        wr_en_c = '0;
        if (rf.reg_wr && (rf.rw != XZR)) begin
            wr_en_c = NUM_PHYS'(1) << rf.rw;
        end
    end

    for (genvar i = 0; i < int'(NUM_PHYS); i++) begin : g_reg
        assign x_d[i] = wr_en_c[i] ? rf.bus_w : x_q[i];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                x_q[i] <= '0;
            end else begin
                x_q[i] <= x_d[i];
            end
        end

        assign view_c[i] = x_q[i];
    end

    // XZR has no storage; the read view fills its slot with a constant zero.
    assign view_c[NUM_ARCH-1] = '0;

    always_comb begin
        rd_a_c = view_c[rf.ra];
        if (rf.ra == XZR) begin
            rd_a_c = '0;
        end else if (rf.reg_wr && (rf.rw == rf.ra)) begin
            rd_a_c = rf.bus_w;
        end
    end

    always_comb begin
        rd_b_c = view_c[rf.rb];
        if (rf.rb == XZR) begin
            rd_b_c = '0;
        end else if (rf.reg_wr && (rf.rw == rf.rb)) begin
            rd_b_c = rf.bus_w;
        end
    end

    assign rf.bus_a_c = rst ? '0 : rd_a_c;
    assign rf.bus_b_c = rst ? '0 : rd_b_c;

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed bench for regfile_bypass: reset, write/read, XZR, bypass, reset-vs-write
// and a small ALU operand check, all against hand-computed values.
module tb_regfile_bypass;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    regfile_bypass_if #(.N(64), .AW(5)) rf ();

    regfile_bypass dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] idx, input logic [63:0] val);
        rf.reg_wr = 1'b1;
        rf.rw     = idx;
        rf.bus_w  = val;
        tick();
        rf.reg_wr = 1'b0;
        #1;
    endtask

    function automatic logic [63:0] alu(input logic [3:0] ctrl, input logic [63:0] a,
                                        input logic [63:0] b);
        case (ctrl)
            4'b0010: return a + b;
            4'b0110: return a - b;
            default: return '0;
        endcase
    endfunction

    logic [63:0] res;

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        rf.ra     = 5'd5;
        rf.rb     = 5'd31;
        rf.rw     = 5'd0;
        rf.reg_wr = 1'b0;
        rf.bus_w  = '0;
        #2;
        chk("reset_busa", rf.bus_a_c, 64'h0);
        chk("reset_busb", rf.bus_b_c, 64'h0);

        // Bypass request during reset must still read zero.
        rf.reg_wr = 1'b1;
        rf.rw     = 5'd5;
        rf.bus_w  = 64'hDEAD_BEEF_0000_0001;
        #1;
        chk("reset_bypass_busa", rf.bus_a_c, 64'h0);
        tick();
        rf.reg_wr = 1'b0;
        rst       = 1'b0;
        #1;
        for (int i = 0; i < 31; i++) begin
            rf.ra = 5'(i);
            rf.rb = 5'(30 - i);
            #1;
            chk($sformatf("post_reset_a_x%0d", i), rf.bus_a_c, 64'h0);
            chk($sformatf("post_reset_b_x%0d", 30 - i), rf.bus_b_c, 64'h0);
        end

        // Write then read.
        write_reg(5'd3, 64'h0123_4567_89AB_CDEF);
        rf.ra = 5'd3;
        rf.rb = 5'd4;
        #1;
        chk("wr_read_x3", rf.bus_a_c, 64'h0123_4567_89AB_CDEF);
        chk("wr_read_x4", rf.bus_b_c, 64'h0);

        // Writing another register must not bypass onto a non-matching port.
        rf.reg_wr = 1'b1;
        rf.rw     = 5'd4;
        rf.bus_w  = 64'h8000_0000_0000_0001;
        #1;
        chk("nobypass_x3", rf.bus_a_c, 64'h0123_4567_89AB_CDEF);
        chk("bypass_x4", rf.bus_b_c, 64'h8000_0000_0000_0001);
        tick();
        rf.reg_wr = 1'b0;
        #1;
        chk("stored_x4", rf.bus_b_c, 64'h8000_0000_0000_0001);

        // XZR: writes are dropped and reads stay zero.
        rf.reg_wr = 1'b1;
        rf.rw     = 5'd31;
        rf.bus_w  = 64'hFFFF_FFFF_FFFF_FFFF;
        rf.ra     = 5'd31;
        rf.rb     = 5'd31;
        #1;
        chk("xzr_pre_a", rf.bus_a_c, 64'h0);
        chk("xzr_pre_b", rf.bus_b_c, 64'h0);
        tick();
        chk("xzr_post_a", rf.bus_a_c, 64'h0);
        chk("xzr_post_b", rf.bus_b_c, 64'h0);
        rf.reg_wr = 1'b0;
        for (int i = 0; i < 31; i++) begin
            rf.ra = 5'(i);
            #1;
            chk($sformatf("xzr_unchanged_x%0d", i), rf.bus_a_c,
                (i == 3) ? 64'h0123_4567_89AB_CDEF :
                (i == 4) ? 64'h8000_0000_0000_0001 : 64'h0);
        end

        // Boundary registers X0 and X30 hold full-width values.
        write_reg(5'd0, 64'hA5A5_5A5A_F00F_0FF0);
        write_reg(5'd30, 64'hFEDC_BA98_7654_3210);
        rf.ra = 5'd0;
        rf.rb = 5'd30;
        #1;
        chk("x0_full", rf.bus_a_c, 64'hA5A5_5A5A_F00F_0FF0);
        chk("x30_full", rf.bus_b_c, 64'hFEDC_BA98_7654_3210);

        // Bypass with both ports on the same register.
        write_reg(5'd7, 64'h10);
        rf.reg_wr = 1'b1;
        rf.rw     = 5'd7;
        rf.bus_w  = 64'h20;
        rf.ra     = 5'd7;
        rf.rb     = 5'd7;
        #1;
        chk("bypass_pre_a", rf.bus_a_c, 64'h20);
        chk("bypass_pre_b", rf.bus_b_c, 64'h20);
        tick();
        rf.reg_wr = 1'b0;
        #1;
        chk("bypass_post_a", rf.bus_a_c, 64'h20);
        chk("bypass_post_b", rf.bus_b_c, 64'h20);

        // Same setup without the write enable: old value stays visible and stored.
        write_reg(5'd7, 64'h10);
        rf.reg_wr = 1'b0;
        rf.rw     = 5'd7;
        rf.bus_w  = 64'h20;
        #1;
        chk("nowr_pre_a", rf.bus_a_c, 64'h10);
        tick();
        chk("nowr_post_a", rf.bus_a_c, 64'h10);

        // Reset asserted mid-cycle during a bypassed write that spans the edge.
        write_reg(5'd9, 64'hAA);
        rf.reg_wr = 1'b1;
        rf.rw     = 5'd9;
        rf.bus_w  = 64'h55;
        rf.ra     = 5'd9;
        rf.rb     = 5'd9;
        #1;
        chk("rstwr_bypass_a", rf.bus_a_c, 64'h55);
        rst = 1'b1;
        #1;
        chk("rstwr_drop_a", rf.bus_a_c, 64'h0);
        chk("rstwr_drop_b", rf.bus_b_c, 64'h0);
        tick();
        rf.reg_wr = 1'b0;
        rst       = 1'b0;
        #1;
        chk("rstwr_x9", rf.bus_a_c, 64'h0);
        rf.ra = 5'd3;
        #1;
        chk("rstwr_x3_cleared", rf.bus_a_c, 64'h0);

        // First write after reset release lands on the next edge.
        write_reg(5'd9, 64'h77);
        rf.ra = 5'd9;
        #1;
        chk("post_release_x9", rf.bus_a_c, 64'h77);

        // Operands into an ALU model.
        write_reg(5'd1, 64'd5);
        write_reg(5'd2, 64'd5);
        rf.ra = 5'd1;
        rf.rb = 5'd2;
        #1;
        res = alu(4'b0110, rf.bus_a_c, rf.bus_b_c);
        chk("alu_sub_result", res, 64'd0);
        chk("alu_sub_zero", 64'(res == 64'd0), 64'd1);
        res = alu(4'b0010, rf.bus_a_c, rf.bus_b_c);
        chk("alu_add_result", res, 64'd10);
        chk("alu_add_zero", 64'(res == 64'd0), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
